// File: rtl/leak_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : leak_pkg                                                   |
// | Description : Shared types and constants for the leak PWM encoder.       |
// |               FSM state encoding and the preamble length multiplier.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package leak_pkg;

    // The preamble lasts PRE_UNITS width units. The widest symbol pulse is
    // 4 units, so a 5-unit pulse can never be confused with a symbol.
    localparam int PRE_UNITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SPACE = 2'd2,
        MARK  = 2'd3
    } leak_state_t;

endpackage : leak_pkg
`default_nettype wire

// File: rtl/leak_sym_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : leak_sym_fifo                                              |
// | Description : Synchronous 2-bit symbol FIFO, first-word-fall-through.    |
// |               dout is valid whenever empty is low.                       |
// | Ports       : clk, rst_all_n (async, active low)                         |
// |               push/din  - write request and data                         |
// |               pop/dout  - read request and head-of-queue data            |
// |               full, empty, count - occupancy status                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module leak_sym_fifo
    import leak_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_all_n,
    input  logic                         push,
    input  logic [1:0]                   din,
    input  logic                         pop,
    output logic [1:0]                   dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [1:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_do_push;
    logic                w_do_pop;

    // Pointers wrap modulo DEPTH explicitly so non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign empty = (r_count == '0);
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : leak_sym_fifo
`default_nettype wire

// File: rtl/leak_pwm_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : leak_pwm_encoder                                           |
// | Description : Buffers the 2-bit leak symbol stream and serialises it on  |
// |               one pin as pulse-width-coded frames. Each burst starts     |
// |               with a 5-unit preamble; each symbol s is a high pulse of   |
// |               (s+1)*UNIT cycles followed by GAP low cycles.              |
// | Ports       : clk, rst_all_n (async, active low)                         |
// |               enable/sym - symbol input, valid when enable is high       |
// |               out        - registered PWM leak line                      |
// |               busy       - FSM active or symbols pending                 |
// |               overflow   - sticky, a symbol was dropped on a full FIFO   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module leak_pwm_encoder
    import leak_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int UNIT  = 4,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_all_n,
    input  logic       enable,
    input  logic [1:0] sym,
    output logic       out,
    output logic       busy,
    output logic       overflow
);

    // The counter only needs to hold the longest interval, the preamble.
    // GAP is assumed not to exceed 5*UNIT.
    localparam int c_CNT_W   = $clog2(PRE_UNITS * UNIT + 1);
    localparam int c_FCNT_W  = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_PRE_LEN = c_CNT_W'(PRE_UNITS * UNIT);
    localparam logic [c_CNT_W-1:0] c_GAP_LEN = c_CNT_W'(GAP);
    localparam logic [c_CNT_W-1:0] c_UNIT    = c_CNT_W'(UNIT);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    leak_state_t          r_state;
    leak_state_t          w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_CNT_W-1:0]   w_mark_len;
    logic                 r_out;
    logic                 w_out_next;
    logic                 r_overflow;
    logic                 w_pop;
    logic                 w_last;
    logic [1:0]           w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [c_FCNT_W-1:0]  w_count;

    leak_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_all_n (rst_all_n),
        .push      (enable),
        .din       (sym),
        .pop       (w_pop),
        .dout      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_last = (r_cnt == c_ONE);

    // The head symbol is consumed exactly when SPACE ends with data waiting.
    assign w_pop = (r_state == SPACE) && w_last && !w_empty;

    // Zero-extend before the add so s=3 yields 4 units, not a 2-bit wrap to 0.
    assign w_mark_len = (c_CNT_W'(w_head) + c_ONE) * c_UNIT;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_out      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_out      <= w_out_next;
            r_overflow <= r_overflow | (enable & w_full & ~w_pop);
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_next = PRE;
                    w_cnt_next   = c_PRE_LEN;
                end
            end
            PRE: begin
                if (w_last) begin
                    w_state_next = SPACE;
                    w_cnt_next   = c_GAP_LEN;
                end else begin
                    w_cnt_next   = r_cnt - c_ONE;
                end
            end
            SPACE: begin
                if (w_last) begin
                    if (!w_empty) begin
                        w_state_next = MARK;
                        w_cnt_next   = w_mark_len;
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_cnt_next   = r_cnt - c_ONE;
                end
            end
            MARK: begin
                if (w_last) begin
                    w_state_next = SPACE;
                    w_cnt_next   = c_GAP_LEN;
                end else begin
                    w_cnt_next   = r_cnt - c_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // out is registered from the next state so the pin is high exactly in
    // the cycles the FSM sits in PRE or MARK.
    always_comb begin
        w_out_next = (w_state_next == PRE) || (w_state_next == MARK);
        busy       = (r_state != IDLE) || (w_count != '0);
    end

    assign out      = r_out;
    assign overflow = r_overflow;

endmodule : leak_pwm_encoder
`default_nettype wire
